systolic_mm_engine: RTL and testbench
=====================================

SYSTOLIC_MM_ENGINE -- requirements
Module: systolic_mm_engine

Interface
REQ-001 SHALL have parameter N, default 8, array dimension (N x N PEs, N >= 2).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, operand element width.
REQ-003 SHALL have parameter ACC_WIDTH, default 32, accumulator/result element width (>= 2*DATA_WIDTH).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  begin a multiply; sampled only in IDLE.
REQ-007 SHALL have port signed_mode  input  1  operands two's-complement when 1; latched at start.
REQ-008 SHALL have port acc_mode  input  1  1 = add into existing C, 0 = clear C first; latched at start.
REQ-009 SHALL have port in_valid  input  1  input beat valid.
REQ-010 SHALL have port in_ready  output  1  engine accepts input beat.
REQ-011 SHALL have port in_a_col  input  N*DATA_WIDTH  column k of A; element i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-012 SHALL have port in_b_row  input  N*DATA_WIDTH  row k of B; element j at [j*DATA_WIDTH +: DATA_WIDTH].
REQ-013 SHALL have port out_valid  output  1  result row valid.
REQ-014 SHALL have port out_ready  input  1  consumer accepts result row.
REQ-015 SHALL have port out_row  output  N*ACC_WIDTH  row r of C; element j at [j*ACC_WIDTH +: ACC_WIDTH].
REQ-016 SHALL have port out_row_idx  output  $clog2(N)  index r of out_row.
REQ-017 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-018 SHALL have port done  output  1  one-cycle pulse when a multiply completes.
REQ-019 SHALL have port cycle_count  output  32  busy-cycle count of the last/current multiply.

Function
REQ-020 SHALL compute C[i][j] = sum over k of A[i][k]*B[k][j], k = 0..N-1, one input beat per k in ascending order.
REQ-021 SHALL implement FSM IDLE -> FEED -> DRAIN -> OUTPUT -> IDLE.
REQ-022 IDLE: in_ready=0, out_valid=0; start=1 latches modes, clears cycle_count, clears all C when acc_mode=0, next state FEED.
REQ-023 FEED: in_ready=1; array and skew lines advance only on in_valid&&in_ready; in_valid=0 freezes entire array (stall, no bubble injected); after N accepted beats -> DRAIN.
REQ-024 SHALL skew internally: row-i A lane delayed i advance steps, column-j B lane delayed j advance steps; zeros fed behind data.
REQ-025 DRAIN: in_ready=0; array advances every cycle for exactly 2*N-1 cycles, then -> OUTPUT.
REQ-026 OUTPUT: out_valid=1, rows r=0..N-1 in order; row advances on out_valid&&out_ready; out_row/out_row_idx held stable while out_ready=0.
REQ-027 After handshake of row N-1: done=1 for the next cycle, state IDLE, cycle_count frozen.
REQ-028 Products: signed_mode=1 sign-extends operands and product to ACC_WIDTH; 0 zero-extends; accumulation wraps modulo 2^ACC_WIDTH, no saturation or flag.
REQ-029 cycle_count SHALL increment every cycle busy=1, saturating at 2^32-1.
REQ-030 start while busy SHALL be ignored; signed_mode/acc_mode changes mid-operation SHALL have no effect.
REQ-031 C SHALL persist across multiplies until cleared by acc_mode=0 start or reset.

Reset
REQ-032 rst_n=0 SHALL asynchronously force IDLE, clear all PE accumulators, skew lines, operand registers, cycle_count to 0; in_ready, out_valid, busy, done, out_row_idx = 0; out_row = 0.
REQ-033 rst_n low mid-operation SHALL abandon the multiply with no done pulse; first start after release behaves as a fresh multiply.

Verification
REQ-034 N=8, A[i][j]=i+j, B[i][j]=(i-j) mod 256, signed_mode=1, acc_mode=0, in_valid/out_ready always 1 -> C[0][0]=140, C[0][1]=112, C[1][0]=168, C[0][7]=0xFFFFFFC8, all 64 match golden, cycle_count=31.
REQ-035 Same data, signed_mode=0 -> C[0][0]=140, C[0][7]=5320, all entries match unsigned golden.
REQ-036 Repeat REQ-034 with acc_mode=1 -> every element doubled (C[0][0]=280); then acc_mode=0 run -> C[0][0]=140.
REQ-037 in_valid low 3 random cycles in FEED, out_ready low 2 cycles on row 4 -> results identical to REQ-034, row 4 held stable, cycle_count=36.
REQ-038 rst_n low during DRAIN -> busy=0, out_valid=0, no done; next REQ-034 run passes unchanged.
REQ-039 start pulsed during FEED and OUTPUT -> no effect; exactly one done pulse per accepted start.

Source files
------------

// File: rtl/systolic_mm_engine.sv
// ============================================================================
// Module   : systolic_mm_engine
// Purpose  : Output-stationary N x N systolic matrix multiplier, C (+)= A*B.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_mm_engine #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      signed_mode,
  input  logic                      acc_mode,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N*DATA_WIDTH-1:0]   in_a_col,
  input  logic [N*DATA_WIDTH-1:0]   in_b_row,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N*ACC_WIDTH-1:0]    out_row,
  output logic [$clog2(N)-1:0]      out_row_idx,
  output logic                      busy,
  output logic                      done,
  output logic [31:0]               cycle_count
);

  localparam int IDX_W  = $clog2(N);
  localparam int STEP_W = $clog2(2*N);
  localparam logic [STEP_W-1:0] c_feed_last  = STEP_W'(N-1);
  localparam logic [STEP_W-1:0] c_drain_last = STEP_W'(2*N-2);
  localparam logic [IDX_W-1:0]  c_row_last   = IDX_W'(N-1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FEED   = 2'd1,
    S_DRAIN  = 2'd2,
    S_OUTPUT = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  w_adv;
  logic                  w_last_row;
  logic                  r_signed;
  logic [STEP_W-1:0]     r_step;
  logic [IDX_W-1:0]      r_row;

  logic [DATA_WIDTH-1:0] w_a_skew [N];
  logic [DATA_WIDTH-1:0] w_b_skew [N];
  logic [DATA_WIDTH-1:0] w_pa     [N][N];
  logic [DATA_WIDTH-1:0] w_pb     [N][N];
  logic [ACC_WIDTH-1:0]  w_prod   [N][N];
  logic [DATA_WIDTH-1:0] r_a      [N][N-1];
  logic [DATA_WIDTH-1:0] r_b      [N-1][N];
  logic [ACC_WIDTH-1:0]  r_acc    [N][N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    w_adv      = 1'b0;
    w_last_row = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_FEED;
      end
      S_FEED: begin
        in_ready = 1'b1;
        w_adv    = in_valid;
        if (in_valid && r_step == c_feed_last) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        w_adv = 1'b1;
        if (r_step == c_drain_last) w_next = S_OUTPUT;
      end
      S_OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready && r_row == c_row_last) begin
          w_last_row = 1'b1;
          w_next     = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_signed    <= 1'b0;
      r_step      <= '0;
      r_row       <= '0;
      cycle_count <= '0;
      done        <= 1'b0;
    end else begin
      done <= w_last_row;
      if (busy && cycle_count != 32'hFFFF_FFFF) cycle_count <= cycle_count + 32'd1;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_signed    <= signed_mode;
            cycle_count <= '0;
            r_step      <= '0;
            r_row       <= '0;
          end
        end
        S_FEED: begin
          if (in_valid) r_step <= (r_step == c_feed_last) ? '0 : r_step + 1'b1;
        end
        S_DRAIN: r_step <= (r_step == c_drain_last) ? '0 : r_step + 1'b1;
        S_OUTPUT: begin
          if (out_ready) r_row <= (r_row == c_row_last) ? '0 : r_row + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Lane i is delayed i advance steps so that operands meet in PE(i,j) on matching k
  for (genvar i = 0; i < N; i++) begin : g_skew
    logic [DATA_WIDTH-1:0] w_a_in;
    logic [DATA_WIDTH-1:0] w_b_in;
    assign w_a_in = (r_state == S_FEED) ? in_a_col[i*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign w_b_in = (r_state == S_FEED) ? in_b_row[i*DATA_WIDTH +: DATA_WIDTH] : '0;
    if (i == 0) begin : g_direct
      assign w_a_skew[i] = w_a_in;
      assign w_b_skew[i] = w_b_in;
    end else begin : g_delay
      logic [DATA_WIDTH-1:0] r_sa [i];
      logic [DATA_WIDTH-1:0] r_sb [i];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int d = 0; d < i; d++) begin
            r_sa[d] <= '0;
            r_sb[d] <= '0;
          end
        end else if (w_adv) begin
          r_sa[0] <= w_a_in;
          r_sb[0] <= w_b_in;
          for (int d = 1; d < i; d++) begin
            r_sa[d] <= r_sa[d-1];
            r_sb[d] <= r_sb[d-1];
          end
        end
      end
      assign w_a_skew[i] = r_sa[i-1];
      assign w_b_skew[i] = r_sb[i-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_pe_row
    for (genvar j = 0; j < N; j++) begin : g_pe_col
      logic signed [DATA_WIDTH:0]     w_ea;
      logic signed [DATA_WIDTH:0]     w_eb;
      logic signed [2*DATA_WIDTH+1:0] w_p;
      if (j == 0) begin : g_a_edge
        assign w_pa[i][j] = w_a_skew[i];
      end else begin : g_a_link
        assign w_pa[i][j] = r_a[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign w_pb[i][j] = w_b_skew[j];
      end else begin : g_b_link
        assign w_pb[i][j] = r_b[i-1][j];
      end
      // One extra top bit makes a single signed multiplier serve both modes
      assign w_ea = {r_signed & w_pa[i][j][DATA_WIDTH-1], w_pa[i][j]};
      assign w_eb = {r_signed & w_pb[i][j][DATA_WIDTH-1], w_pb[i][j]};
      assign w_p  = w_ea * w_eb;
      if (ACC_WIDTH > 2*DATA_WIDTH+2) begin : g_ext
        assign w_prod[i][j] = {{(ACC_WIDTH-2*DATA_WIDTH-2){w_p[2*DATA_WIDTH+1]}}, w_p};
      end else begin : g_trunc
        assign w_prod[i][j] = w_p[ACC_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) r_acc[i][j] <= '0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N-1; j++) r_a[i][j] <= '0;
      for (int i = 0; i < N-1; i++)
        for (int j = 0; j < N; j++) r_b[i][j] <= '0;
    end else if (r_state == S_IDLE && start && !acc_mode) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) r_acc[i][j] <= '0;
    end else if (w_adv) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) r_acc[i][j] <= r_acc[i][j] + w_prod[i][j];
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N-1; j++) r_a[i][j] <= w_pa[i][j];
      for (int i = 0; i < N-1; i++)
        for (int j = 0; j < N; j++) r_b[i][j] <= w_pb[i][j];
    end
  end

  always_comb begin
    out_row = '0;
    for (int j = 0; j < N; j++)
      if (out_valid) out_row[j*ACC_WIDTH +: ACC_WIDTH] = r_acc[r_row][j];
  end

  assign out_row_idx = r_row;

endmodule

`default_nettype wire

// File: tb/tb_systolic_mm_engine.sv
// ============================================================================
// Module   : tb_systolic_mm_engine
// Purpose  : Scoreboard bench for systolic_mm_engine (N=8, 8-bit, 32-bit acc).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_systolic_mm_engine;

  localparam int N  = 8;
  localparam int DW = 8;
  localparam int AW = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start, signed_mode, acc_mode, in_valid, out_ready;
  logic              in_ready, out_valid, busy, done;
  logic [N*DW-1:0]   in_a_col, in_b_row;
  logic [N*AW-1:0]   out_row;
  logic [2:0]        out_row_idx;
  logic [31:0]       cycle_count;

  int n_total = 0;
  int n_bad   = 0;
  int n_done  = 0;

  logic [AW-1:0]     c_model [N][N];
  logic [AW-1:0]     cap     [N][N];
  logic [N*AW-1:0]   sb_row [$];
  int                sb_idx [$];

  systolic_mm_engine #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_mode (signed_mode),
    .acc_mode    (acc_mode),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a_col    (in_a_col),
    .in_b_row    (in_b_row),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_row     (out_row),
    .out_row_idx (out_row_idx),
    .busy        (busy),
    .done        (done),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) n_done++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference C update: A[i][k]=i+k, B[k][j]=(k-j) mod 256
  task automatic model_run(input bit sm, input bit am);
    logic [7:0] av, bv;
    int ai, bi;
    logic [N*AW-1:0] row;
    if (!am)
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) c_model[i][j] = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        for (int k = 0; k < N; k++) begin
          av = 8'(i + k);
          bv = 8'(k - j);
          ai = sm ? int'($signed(av)) : int'(av);
          bi = sm ? int'($signed(bv)) : int'(bv);
          c_model[i][j] = c_model[i][j] + 32'(ai * bi);
        end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) row[j*AW +: AW] = c_model[i][j];
      sb_row.push_back(row);
      sb_idx.push_back(i);
    end
  endtask

  task automatic do_start(input bit sm, input bit am);
    start = 1'b1; signed_mode = sm; acc_mode = am;
    tick;
    start = 1'b0; signed_mode = !sm; acc_mode = !am;
    check("busy_after_start", busy, 1);
  endtask

  task automatic feed(input int stalls, input bit poke);
    int stall_at [N];
    for (int k = 0; k < N; k++) stall_at[k] = 0;
    for (int s = 0; s < stalls; s++) stall_at[$urandom_range(0, N-1)]++;
    for (int k = 0; k < N; k++) begin
      while (stall_at[k] > 0) begin
        in_valid = 1'b0;
        tick;
        stall_at[k]--;
      end
      for (int e = 0; e < N; e++) begin
        in_a_col[e*DW +: DW] = 8'(e + k);
        in_b_row[e*DW +: DW] = 8'(k - e);
      end
      in_valid = 1'b1;
      if (poke && k == 3) start = 1'b1;
      check("in_ready", in_ready, 1);
      tick;
      start = 1'b0;
    end
    in_valid = 1'b0;
    in_a_col = '0;
    in_b_row = '0;
  endtask

  task automatic run_mm(input bit sm, input bit am, input int stalls, input int hold,
                        input bit poke, input int exp_cc);
    int hold_left, budget, d0, r;
    bit rdy;
    model_run(sm, am);
    d0 = n_done;
    do_start(sm, am);
    feed(stalls, poke);
    hold_left = hold;
    budget = 0;
    while (sb_row.size() > 0) begin
      if (budget++ > 200) begin
        check("out_timeout", 0, 1);
        sb_row.delete();
        sb_idx.delete();
        break;
      end
      if (out_valid) begin
        r = sb_idx[0];
        rdy = !(r == 4 && hold_left > 0);
        out_ready = rdy;
        check("row_idx", out_row_idx, r);
        for (int j = 0; j < N; j++) begin
          check("elem", out_row[j*AW +: AW], sb_row[0][j*AW +: AW]);
          cap[r][j] = out_row[j*AW +: AW];
        end
        if (poke && r == 2) start = 1'b1;
        if (!rdy) hold_left--;
        tick;
        start = 1'b0;
        if (rdy) begin
          void'(sb_row.pop_front());
          void'(sb_idx.pop_front());
        end
      end else begin
        tick;
      end
    end
    out_ready = 1'b1;
    check("done_pulse", done, 1);
    check("busy_idle", busy, 0);
    check("out_valid_idle", out_valid, 0);
    check("cycle_count", cycle_count, exp_cc);
    tick;
    check("done_low", done, 0);
    check("done_count", n_done, d0 + 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0; acc_mode = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; in_a_col = '0; in_b_row = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_done", done, 0);
    check("rst_cycles", cycle_count, 0);
    check("rst_row_idx", out_row_idx, 0);
    check("rst_out_row_lo", out_row[63:0], 0);
    rst_n = 1'b1;
    tick;

    run_mm(1'b1, 1'b0, 0, 0, 1'b0, 31);
    check("s_c00", cap[0][0], 140);
    check("s_c01", cap[0][1], 112);
    check("s_c10", cap[1][0], 168);
    check("s_c07", cap[0][7], 32'hFFFF_FFC8);

    run_mm(1'b0, 1'b0, 0, 0, 1'b0, 31);
    check("u_c00", cap[0][0], 140);
    check("u_c07", cap[0][7], 5320);

    run_mm(1'b1, 1'b0, 0, 0, 1'b0, 31);
    run_mm(1'b1, 1'b1, 0, 0, 1'b0, 31);
    check("acc_c00", cap[0][0], 280);

    run_mm(1'b1, 1'b0, 3, 2, 1'b1, 36);
    check("stall_c00", cap[0][0], 140);
    check("stall_c07", cap[0][7], 32'hFFFF_FFC8);

    // Abandon a multiply mid-drain
    d0 = n_done;
    do_start(1'b1, 1'b0);
    feed(0, 1'b0);
    repeat (3) tick;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_cycles", cycle_count, 0);
    tick;
    rst_n = 1'b1;
    repeat (30) tick;
    check("arst_no_done", n_done, d0);
    check("arst_still_idle", busy, 0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) c_model[i][j] = '0;

    run_mm(1'b1, 1'b0, 0, 0, 1'b0, 31);
    check("post_rst_c00", cap[0][0], 140);
    check("post_rst_c10", cap[1][0], 168);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
